note_tone_gen: RTL



---
 rtl/piano_pkg.sv | 24 ++
 rtl/note_period_lut.sv | 41 ++++
 rtl/note_tone_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared constants and types for the piano tone path
//
// Holds the base half-period table (100 MHz cycles, indexed by key code - 2),
// the valid key-code and octave-shift ranges, and the tone FSM state type.
package piano_pkg;

    localparam int NOTE_MIN  = 2;
    localparam int NOTE_MAX  = 11;
    localparam int OCT_MIN   = -3;
    localparam int OCT_MAX   = 3;
    localparam int NUM_NOTES = NOTE_MAX - NOTE_MIN + 1;

    // C4 D4 E4 F4 G4 A4 B4 C5 D5 E5
    localparam logic [17:0] BASE_HALF [0:NUM_NOTES-1] = '{
        18'd191113, 18'd170262, 18'd151686, 18'd143172, 18'd127551,
        18'd113636, 18'd101239, 18'd95556,  18'd85131,  18'd75843
    };

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/note_period_lut.sv
// rtl/note_period_lut.sv - key code + octave shift to half-period lookup
//
// Purely combinational.
//   data         : key code, 2..11 are notes
//   octave_shift : signed octave offset, clamped to -3..+3
//   half         : half-period in clock cycles for the shifted note
//   code_ok      : data is a valid note code
module note_period_lut
    import piano_pkg::*;
#(
    parameter int CNT_W = 21
) (
    input  logic [7:0]        data,
    input  logic signed [3:0] octave_shift,
    output logic [CNT_W-1:0]  half,
    output logic              code_ok
);

    logic [3:0]       idx;
    logic [CNT_W-1:0] base_ext;
    logic             left;
    logic [1:0]       shamt;

    always_comb begin
        code_ok  = (data >= 8'(NOTE_MIN)) && (data <= 8'(NOTE_MAX));
        idx      = code_ok ? 4'(data - 8'(NOTE_MIN)) : 4'd0;
        base_ext = CNT_W'(BASE_HALF[idx]);

        // Negative shift lowers the pitch (longer half period), positive raises it.
        if (octave_shift[3]) begin
            left  = 1'b1;
            shamt = (int'(octave_shift) < OCT_MIN) ? 2'(-OCT_MIN) : 2'(-int'(octave_shift));
        end else begin
            left  = 1'b0;
            shamt = (int'(octave_shift) > OCT_MAX) ? 2'(OCT_MAX) : 2'(octave_shift);
        end

        half = left ? (base_ext << shamt) : (base_ext >> shamt);
    end

endmodule

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - glitch-free square-wave tone generator for the buzzer
//
//   clk          : 100 MHz clock
//   reset        : asynchronous, active-high
//   octave_shift : signed octave offset (clamped to -3..+3)
//   data         : key code, 2..11 play a note, anything else is silence
//   note_active  : level-sensitive note gate
//   buzzer       : registered 50 % duty square wave
//   playing      : registered, high while a tone is being produced
module note_tone_gen
    import piano_pkg::*;
#(
    parameter int CNT_W = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [3:0] octave_shift,
    input  logic [7:0]        data,
    input  logic              note_active,
    output logic              buzzer,
    output logic              playing
);

    logic [CNT_W-1:0] half;
    logic             code_ok;
    logic             valid;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] half_q, half_n;
    logic             buzzer_n;
    logic             playing_n;

    note_period_lut #(.CNT_W(CNT_W)) u_lut (
        .data         (data),
        .octave_shift (octave_shift),
        .half         (half),
        .code_ok      (code_ok)
    );

    assign valid = code_ok && note_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            half_q  <= '0;
            buzzer  <= 1'b0;
            playing <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            half_q  <= half_n;
            buzzer  <= buzzer_n;
            playing <= playing_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        half_n    = half_q;
        buzzer_n  = buzzer;
        playing_n = playing;

        case (state)
            IDLE: begin
                buzzer_n  = 1'b0;
                cnt_n     = '0;
                playing_n = 1'b0;
                if (valid) begin
                    state_n   = PLAY;
                    half_n    = half;
                    buzzer_n  = 1'b1;
                    playing_n = 1'b1;
                end
            end
            PLAY: begin
                // Gate drop beats a coincident toggle: silence is immediate.
                if (!valid) begin
                    state_n   = IDLE;
                    buzzer_n  = 1'b0;
                    cnt_n     = '0;
                    playing_n = 1'b0;
                end else if (cnt == half_q - CNT_W'(1)) begin
                    // Pitch changes are picked up only here, so a level never
                    // changes length part-way through.
                    buzzer_n = ~buzzer;
                    cnt_n    = '0;
                    half_n   = half;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
